window_fetch: RTL and testbench
===============================

Name: window_fetch

Overview:
- Upstream feeder for conv_pool.
- Walks an RGB image held in a pixel SRAM with a 4x4 window at stride 2, so each window yields exactly one pooled output pixel downstream.
- Assembles each window into three 128-bit channel vectors (image_4x4_r/g/b) and hands them over on a valid/ready handshake.
- Reuses the two overlapping columns when stepping right, so a horizontal step costs 8 reads instead of 16.

Parameters:
- IMG_W, 512, image width in pixels (even, >=4)
- IMG_H, 512, image height in pixels (even, >=4)
- ADDR_W, 18, pixel memory address width (must satisfy 2^ADDR_W >= IMG_W*IMG_H)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse; begins a frame when idle
- mem_re  out  1  pixel memory read enable
- mem_addr  out  ADDR_W  pixel address = row*IMG_W + col
- mem_rdata  in  24  {r[23:16], g[15:8], b[7:0]}; valid the cycle after mem_re
- win_valid  out  1  window outputs valid
- win_ready  in  1  downstream accepts window
- image_4x4_r  out  128  red window
- image_4x4_g  out  128  green window
- image_4x4_b  out  128  blue window
- win_idx  out  16  output-pixel index of the current window (row-major over OUT_W x OUT_H)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last window is accepted

Behaviour:
- Derived sizes: OUT_W=(IMG_W-4)/2+1, OUT_H=(IMG_H-4)/2+1. Defaults give 255x255 = 65025 windows.
- Packing: pixel(i,j), with i = window row 0..3 and j = window col 0..3, sits at bits [(4*i+j)*8 +: 8] of each channel vector.
- Reset (async, rst=0) values:
  - mem_re=0, mem_addr=0, win_valid=0, win_idx=0, busy=0, done=0.
  - image_4x4_* = 0; row/col counters = 0; state = IDLE.
  - Any in-flight read data is discarded.
- State IDLE:
  - start=1 -> FILL (16 reads), busy=1, window origin (row0,col0)=(0,0).
  - start while busy is ignored.
- State FILL:
  - mem_re high for 16 consecutive cycles.
  - Read order is column-major: cols c0..c0+3, and for each col rows r0..r0+3.
  - Each returned word is written into its window slot the following cycle.
- State STEP:
  - Entered after a handshake when the next origin is in the same window row.
  - Window shifts left by 2 columns: slots j=2,3 move to j=0,1.
  - 8 reads, column-major, fetch cols c0+2 and c0+3 (new origin).
- State DRAIN: one cycle to capture the final read word.
- State PRESENT:
  - win_valid=1. image_4x4_* and win_idx held stable until win_valid&&win_ready.
  - Outputs may change freely while win_valid=0. win_ready while win_valid=0 has no effect.
- Advance on handshake:
  - win_idx+1.
  - If col index < OUT_W-1: col+1 -> STEP.
  - Else col=0, row+1, origin row += 2 -> FILL (full 16 reads, no reuse across rows).
  - If the accepted window was win_idx = OUT_W*OUT_H-1: done=1 for one cycle, busy=0, -> IDLE. win_idx resets to 0 on the next start.
- Latency, cycle 0 = edge sampling start:
  - mem_re cycles 1..16, last data cycle 17, win_valid from cycle 18.
  - After a handshake at edge E: STEP gives win_valid at E+10; FILL gives it at E+18.
- Addresses are computed with ADDR_W-bit arithmetic. The maximum address IMG_W*IMG_H-1 must be reached exactly, with no wrap.
- Backpressure: win_ready held low stalls PRESENT indefinitely; no reads are issued while stalled.
- Reset mid-frame: block returns to IDLE immediately; the next start restarts at window 0.

Optional Feature:
- Macro WINDOW_FETCH_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [31:0] counting cycles with win_valid=1 && win_ready=0.
  - Cleared by reset and on an accepted start; saturates at 0xFFFFFFFF; holds its value after done.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Common setup: IMG_W=IMG_H=8 (3x3 = 9 windows). Memory model: r=row*8+col, g=255-(row*8+col), b=col. win_ready tied 1 unless stated.
- First window: start -> mem_re high cycles 1..16, win_valid rises cycle 18, win_idx=0, image_4x4_r[7:0]=0, [31:24]=3, [39:32]=8, [127:120]=27; image_4x4_g[7:0]=255.
- Horizontal step: accept window 0 -> exactly 8 reads at addresses 4,12,20,28,5,13,21,29; win_valid 10 cycles after the handshake; win_idx=1, r[7:0]=2, r[127:120]=29.
- Row wrap: accept win_idx 2 -> 16 reads starting at address 16; win_idx=3, r[7:0]=16, r[127:120]=43; b[7:0]=0.
- Frame end and backpressure: hold win_ready=0 for 5 cycles on win_idx 4 -> outputs stable, no mem_re; after win_idx 8 is accepted, done pulses once, busy=0. With WINDOW_FETCH_STALL_CNT_EN, stall_cnt=5.
- Reset mid-frame: drop rst during the STEP reads of window 1 -> all outputs 0 immediately; start again -> win_idx=0, r[7:0]=0.
- Start while busy: pulse start during PRESENT of win_idx 2 -> ignored, sequence and win_idx unchanged.

Source files
------------

// File: rtl/window_fetch.sv
// window_fetch: walks an RGB pixel SRAM with a 4x4 window at stride 2 and presents
// each window as three packed 128-bit channel vectors. First window is valid 18 cycles
// after start; a step right costs 10 cycles and a move to the next window row costs 18.
// Backpressure: win_ready low holds PRESENT indefinitely with stable outputs and no reads.
//
// Ports:
//   clk, rst (async active-low)    clock / reset
//   start                          one-cycle pulse, begins a frame when idle
//   mem_re, mem_addr, mem_rdata    pixel SRAM read port (data returns one cycle after mem_re)
//   win_valid, win_ready           window handshake
//   image_4x4_r/g/b                pixel(i,j) at bits [(4*i+j)*8 +: 8]
//   win_idx                        row-major output-pixel index of the presented window
//   busy, done                     frame in progress / one-cycle end-of-frame pulse
//   stall_cnt                      present only with WINDOW_FETCH_STALL_CNT_EN defined:
//                                  cycles spent with win_valid=1 and win_ready=0

module window_fetch #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [127:0]      image_4x4_r,
    output logic [127:0]      image_4x4_g,
    output logic [127:0]      image_4x4_b,
    output logic [15:0]       win_idx,
    output logic              busy,
    output logic              done
`ifdef WINDOW_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int OUT_W = (IMG_W - 4) / 2 + 1;
    localparam int OUT_H = (IMG_H - 4) / 2 + 1;

    localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STEP,
        S_DRAIN,
        S_PRESENT
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        cnt;        // read counter within FILL (0..15) or STEP (0..7)
    logic [15:0]       col_idx;    // output column of current window
    logic [15:0]       row_idx;    // output row of current window
    logic [ADDR_W-1:0] org_addr;   // address of the window's top-left pixel

    logic              rd_pend;    // a read issued last cycle returns data now
    logic [3:0]        rd_slot;    // {i, j} slot that the returning word fills

    logic [1:0]        rd_row;
    logic [1:0]        rd_col;
    logic [ADDR_W-1:0] row_off;

    logic              hs;
    logic              col_last;
    logic              frame_last;

    assign hs         = (state == S_PRESENT) && win_ready;
    assign col_last   = (col_idx == 16'(OUT_W - 1));
    assign frame_last = col_last && (row_idx == 16'(OUT_H - 1));

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM next state and decoded outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        win_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                mem_re = 1'b1;
                if (cnt == 4'd15) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_STEP: begin
                mem_re = 1'b1;
                if (cnt == 4'd7) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    if (frame_last) begin
                        state_nxt = S_IDLE;
                    end else if (col_last) begin
                        state_nxt = S_FILL;
                    end else begin
                        state_nxt = S_STEP;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Read address generation. Column-major inside the window:
    // FILL covers window cols 0..3, STEP only the two new cols 2..3.
    // ---------------------------------------------------------------
    always_comb begin
        rd_row = cnt[1:0];
        rd_col = (state == S_STEP) ? {1'b1, cnt[2]} : cnt[3:2];
        case (rd_row)
            2'd0:    row_off = '0;
            2'd1:    row_off = W_A;
            2'd2:    row_off = W_A + W_A;
            default: row_off = W_A + W_A + W_A;
        endcase
        mem_addr = mem_re ? (org_addr + row_off + ADDR_W'(rd_col)) : '0;
    end

    // ---------------------------------------------------------------
    // Counters, read pipeline and window assembly
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            col_idx     <= '0;
            row_idx     <= '0;
            org_addr    <= '0;
            rd_pend     <= 1'b0;
            rd_slot     <= '0;
            win_idx     <= '0;
            done        <= 1'b0;
            image_4x4_r <= '0;
            image_4x4_g <= '0;
            image_4x4_b <= '0;
        end else begin
            done    <= hs && frame_last;
            rd_pend <= mem_re;
            rd_slot <= {rd_row, rd_col};

            if (mem_re && (state_nxt == state)) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= '0;
            end

            // Returning word lands one cycle after its read was issued.
            if (rd_pend) begin
                image_4x4_r[{rd_slot, 3'b000} +: 8] <= mem_rdata[23:16];
                image_4x4_g[{rd_slot, 3'b000} +: 8] <= mem_rdata[15:8];
                image_4x4_b[{rd_slot, 3'b000} +: 8] <= mem_rdata[7:0];
            end

            if (state == S_IDLE && start) begin
                win_idx  <= '0;
                col_idx  <= '0;
                row_idx  <= '0;
                org_addr <= '0;
            end

            if (hs) begin
                win_idx <= win_idx + 16'd1;
                if (col_last) begin
                    // Rightmost origin is col IMG_W-4; the next row's origin is
                    // two image rows down at col 0, i.e. +IMG_W+4.
                    col_idx  <= '0;
                    row_idx  <= row_idx + 16'd1;
                    org_addr <= org_addr + W_A + ADDR_W'(4);
                end else begin
                    col_idx  <= col_idx + 16'd1;
                    org_addr <= org_addr + ADDR_W'(2);
                    // Reuse the overlapping columns: j=2,3 become j=0,1.
                    for (int i = 0; i < 4; i++) begin
                        image_4x4_r[i*32 +: 16] <= image_4x4_r[i*32+16 +: 16];
                        image_4x4_g[i*32 +: 16] <= image_4x4_g[i*32+16 +: 16];
                        image_4x4_b[i*32 +: 16] <= image_4x4_b[i*32+16 +: 16];
                    end
                end
            end
        end
    end

`ifdef WINDOW_FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cnt <= '0;
        end else if (win_valid && !win_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_window_fetch.sv
module tb_window_fetch;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst;
    logic              start;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_rdata;
    logic              win_valid;
    logic              win_ready;
    logic [127:0]      image_4x4_r;
    logic [127:0]      image_4x4_g;
    logic [127:0]      image_4x4_b;
    logic [15:0]       win_idx;
    logic              busy;
    logic              done;
`ifdef WINDOW_FETCH_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] addr_q[$];

    window_fetch #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .image_4x4_r(image_4x4_r),
        .image_4x4_g(image_4x4_g),
        .image_4x4_b(image_4x4_b),
        .win_idx    (win_idx),
        .busy       (busy),
        .done       (done)
`ifdef WINDOW_FETCH_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel SRAM: r = row*8+col (= address), g = 255-r, b = col; one-cycle read latency.
    function automatic logic [23:0] pix(input int addr);
        logic [7:0] r;
        r = 8'(addr);
        return {r, 8'(255 - addr), 8'(addr % IMG_W)};
    endfunction

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= pix(int'(mem_addr));
    end

    // Expected channel vector for a window whose origin is image pixel (r0, c0).
    function automatic logic [127:0] exp_ch(input int ch, input int r0, input int c0);
        logic [127:0] v;
        logic [23:0]  p;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                p = pix((r0 + i) * IMG_W + c0 + j);
                case (ch)
                    0:       v[(4*i+j)*8 +: 8] = p[23:16];
                    1:       v[(4*i+j)*8 +: 8] = p[15:8];
                    default: v[(4*i+j)*8 +: 8] = p[7:0];
                endcase
            end
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the edge that launched a fetch (start or handshake).
    // Cycle 1 is the cycle right after that edge.
    task automatic run_to_valid(output int t_valid, output int nreads,
                                output int first_re, output int last_re);
        int t;
        t        = 1;
        nreads   = 0;
        first_re = -1;
        last_re  = -1;
        addr_q.delete();
        while (!win_valid && t < 100) begin
            if (mem_re) begin
                addr_q.push_back(mem_addr);
                if (first_re < 0) first_re = t;
                last_re = t;
                nreads++;
            end
            tick();
            t++;
        end
        t_valid = win_valid ? t : -1;
        check("valid_timeout", {127'd0, win_valid}, 128'd1);
    endtask

    task automatic check_window(input string tag, input int k);
        int r0;
        int c0;
        r0 = 2 * (k / 3);
        c0 = 2 * (k % 3);
        check({tag, "_idx"}, 128'(win_idx), 128'(k));
        check({tag, "_r"}, image_4x4_r, exp_ch(0, r0, c0));
        check({tag, "_g"}, image_4x4_g, exp_ch(1, r0, c0));
        check({tag, "_b"}, image_4x4_b, exp_ch(2, r0, c0));
    endtask

    initial begin
        int tv;
        int nr;
        int fr;
        int lr;
        logic [127:0] snap_r;
        logic [ADDR_W-1:0] exp_step[8];
        exp_step = '{6'd4, 6'd12, 6'd20, 6'd28, 6'd5, 6'd13, 6'd21, 6'd29};

        rst       = 1'b0;
        start     = 1'b0;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_mem_re", 128'(mem_re), 128'd0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        check("rst_win_valid", 128'(win_valid), 128'd0);
        check("rst_win_idx", 128'(win_idx), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_img_r", image_4x4_r, 128'd0);
        check("rst_img_b", image_4x4_b, 128'd0);

        rst = 1'b1;
        tick();

        // First window
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_valid(tv, nr, fr, lr);
        check("w0_first_re", 128'(fr), 128'd1);
        check("w0_last_re", 128'(lr), 128'd16);
        check("w0_nreads", 128'(nr), 128'd16);
        check("w0_valid_cycle", 128'(tv), 128'd18);
        check("w0_busy", 128'(busy), 128'd1);
        check("w0_r00", 128'(image_4x4_r[7:0]), 128'd0);
        check("w0_r03", 128'(image_4x4_r[31:24]), 128'd3);
        check("w0_r10", 128'(image_4x4_r[39:32]), 128'd8);
        check("w0_r33", 128'(image_4x4_r[127:120]), 128'd27);
        check("w0_g00", 128'(image_4x4_g[7:0]), 128'd255);
        check_window("w0", 0);

        // Horizontal step
        tick();
        run_to_valid(tv, nr, fr, lr);
        check("w1_nreads", 128'(nr), 128'd8);
        check("w1_valid_cycle", 128'(tv), 128'd10);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("w1_addr%0d", i),
                  (i < addr_q.size()) ? 128'(addr_q[i]) : 128'hDEAD, 128'(exp_step[i]));
        end
        check("w1_r00", 128'(image_4x4_r[7:0]), 128'd2);
        check("w1_r33", 128'(image_4x4_r[127:120]), 128'd29);
        check_window("w1", 1);

        // Window 2, with a start pulse during PRESENT that must be ignored
        tick();
        run_to_valid(tv, nr, fr, lr);
        check_window("w2", 2);
        start = 1'b1;
        tick();
        start = 1'b0;

        // Row wrap
        run_to_valid(tv, nr, fr, lr);
        check("w3_nreads", 128'(nr), 128'd16);
        check("w3_valid_cycle", 128'(tv), 128'd18);
        check("w3_addr0", (addr_q.size() > 0) ? 128'(addr_q[0]) : 128'hDEAD, 128'd16);
        check("w3_r00", 128'(image_4x4_r[7:0]), 128'd16);
        check("w3_r33", 128'(image_4x4_r[127:120]), 128'd43);
        check("w3_b00", 128'(image_4x4_b[7:0]), 128'd0);
        check_window("w3", 3);

        // Backpressure on window 4
        tick();
        run_to_valid(tv, nr, fr, lr);
        check_window("w4", 4);
        win_ready = 1'b0;
        snap_r    = image_4x4_r;
        for (int s = 0; s < 5; s++) begin
            tick();
            check($sformatf("stall%0d_valid", s), 128'(win_valid), 128'd1);
            check($sformatf("stall%0d_re", s), 128'(mem_re), 128'd0);
            check($sformatf("stall%0d_r", s), image_4x4_r, snap_r);
            check($sformatf("stall%0d_idx", s), 128'(win_idx), 128'd4);
        end
`ifdef WINDOW_FETCH_STALL_CNT_EN
        check("stall_cnt", 128'(stall_cnt), 128'd5);
`endif
        win_ready = 1'b1;

        // Remaining windows through frame end
        for (int k = 5; k < 9; k++) begin
            tick();
            run_to_valid(tv, nr, fr, lr);
            check_window($sformatf("w%0d", k), k);
        end
        tick();
        check("end_done", 128'(done), 128'd1);
        check("end_busy", 128'(busy), 128'd0);
        tick();
        check("end_done_pulse", 128'(done), 128'd0);
        check("end_valid", 128'(win_valid), 128'd0);
`ifdef WINDOW_FETCH_STALL_CNT_EN
        check("stall_cnt_hold", 128'(stall_cnt), 128'd5);
`endif

        // Reset mid-frame during STEP reads of window 1
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef WINDOW_FETCH_STALL_CNT_EN
        check("stall_cnt_clr", 128'(stall_cnt), 128'd0);
`endif
        run_to_valid(tv, nr, fr, lr);
        check("f2_w0_idx", 128'(win_idx), 128'd0);
        tick();
        tick();
        tick();
        check("mid_step_re", 128'(mem_re), 128'd1);
        rst = 1'b0;
        #1;
        check("arst_mem_re", 128'(mem_re), 128'd0);
        check("arst_mem_addr", 128'(mem_addr), 128'd0);
        check("arst_valid", 128'(win_valid), 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_idx", 128'(win_idx), 128'd0);
        check("arst_img_r", image_4x4_r, 128'd0);
        check("arst_img_g", image_4x4_g, 128'd0);
        tick();
        rst = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_valid(tv, nr, fr, lr);
        check("f3_valid_cycle", 128'(tv), 128'd18);
        check("f3_r00", 128'(image_4x4_r[7:0]), 128'd0);
        check_window("f3_w0", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
